// File: rtl/insn_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : insn_obi_pkg
// Description : Shared types, limits and helpers for the instruction-side
//               OBI responder (entry layout, depth/latency ceilings and the
//               saturating age step).
// Revision    : 1.0 - initial release
// ============================================================================
package insn_obi_pkg;

  // Largest supported number of outstanding granted requests.
  localparam int DEPTH_MAX   = 8;

  // Largest supported grant-to-response latency; fits in the 4-bit age field.
  localparam int LATENCY_MAX = 15;

  // One outstanding request: the accepted address and how long it has waited.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  age;
  } entry_t;

  // Advance an age by one cycle, holding at the latency ceiling so the field
  // never wraps while a response is being stalled.
  function automatic logic [3:0] age_step(input logic [3:0] age,
                                          input logic [3:0] lim);
    return (age >= lim) ? lim : age + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/insn_obi_fifo.sv
`default_nettype none
// ============================================================================
// Module      : insn_obi_fifo
// Description : In-order store of outstanding granted requests. Each entry
//               carries its address and an age that counts clock edges since
//               its grant, saturating at LATENCY. Exposes the head entry and
//               the occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_obi_fifo
  import insn_obi_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [31:0]                push_addr_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  // A single-entry store still needs a one-bit pointer; it simply stays 0.
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       LAT      = 4'(LATENCY);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   wptr_d;
  logic [PTR_W-1:0]   rptr_q;
  logic [PTR_W-1:0]   rptr_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  // Pointers wrap explicitly at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: age every live entry, retire the head on pop, append on push.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        mem_d[i].age = age_step(mem_q[i].age, LAT);
      end
    end

    // The top only pops a non-empty store, so rptr_q always names a live entry.
    if (pop_i) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = ptr_next(rptr_q);
    end

    // The grant edge itself counts as the first cycle of waiting, so a new
    // entry is written already aged by one step. With LATENCY=1 this makes
    // the response eligible in the cycle right after the grant.
    if (push_i) begin
      mem_d[wptr_q].addr = push_addr_i;
      mem_d[wptr_q].age  = age_step(4'd0, LAT);
      valid_d[wptr_q]    = 1'b1;
      wptr_d             = ptr_next(wptr_q);
    end

    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every outstanding request at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/insn_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : insn_obi_responder
// Description : Instruction-side OBI responder. Grants requests while room
//               remains, returns read data from an external combinational
//               memory model in grant order once each request has waited
//               LATENCY cycles, and honours external grant/response stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_obi_responder
  import insn_obi_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        gnt_stall_i,
  input  logic        rvalid_stall_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int         CNT_W = $clog2(DEPTH + 1);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  entry_t             head;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  insn_obi_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_addr_i (instr_addr_i),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Grant/response decode. Grant looks only at the registered count, so a
  // full store refuses a new request even when the head pops this cycle.
  // Reset is folded into the grant because an empty store would otherwise
  // grant a request presented while rst_ni is held low.
  always_comb begin
    instr_gnt_o    = rst_ni & instr_req_i & ~gnt_stall_i
                   & (count < CNT_W'(DEPTH));
    instr_rvalid_o = (count != '0) & (head.age >= LAT) & ~rvalid_stall_i;
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    mem_addr_o     = head.addr;
    push           = instr_gnt_o;
    pop            = instr_rvalid_o;
  end

endmodule
`default_nettype wire

// File: tb/tb_insn_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_obi_responder
// Description : Self-checking bench for insn_obi_responder. Directed cycle
//               vectors check grant/rvalid per cycle and queue expected read
//               data; a monitor pops and compares whenever rvalid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_obi_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;

  // DUT 1: DEPTH=2, LATENCY=1
  logic        req, gs, rs;
  logic [31:0] addr;
  logic        gnt, rv;
  logic [31:0] rdata, maddr, mrdata;

  // DUT 3: DEPTH=2, LATENCY=3
  logic        d3_req;
  logic [31:0] d3_addr;
  logic        d3_gnt, d3_rv;
  logic [31:0] d3_rdata, d3_maddr, d3_mrdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  // Memory model content: a fixed scramble of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign mrdata    = mem_f(maddr);
  assign d3_mrdata = mem_f(d3_maddr);

  insn_obi_responder #(.DEPTH(2), .LATENCY(1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_i    (req),
    .instr_addr_i   (addr),
    .instr_gnt_o    (gnt),
    .instr_rvalid_o (rv),
    .instr_rdata_o  (rdata),
    .gnt_stall_i    (gs),
    .rvalid_stall_i (rs),
    .mem_addr_o     (maddr),
    .mem_rdata_i    (mrdata)
  );

  insn_obi_responder #(.DEPTH(2), .LATENCY(3)) dut3 (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_i    (d3_req),
    .instr_addr_i   (d3_addr),
    .instr_gnt_o    (d3_gnt),
    .instr_rvalid_o (d3_rv),
    .instr_rdata_o  (d3_rdata),
    .gnt_stall_i    (1'b0),
    .rvalid_stall_i (1'b0),
    .mem_addr_o     (d3_maddr),
    .mem_rdata_i    (d3_mrdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, in-order data check on every response.
  always @(negedge clk) begin
    chk("gnt_without_req", {31'd0, gnt & ~req}, 32'd0);
    chk("rvalid_with_count0", {31'd0, rv & (dut.u_fifo.count_q == '0)}, 32'd0);
    chk("d3_gnt_without_req", {31'd0, d3_gnt & ~d3_req}, 32'd0);
    chk("d3_rvalid_with_count0", {31'd0, d3_rv & (dut3.u_fifo.count_q == '0)}, 32'd0);
    if (rv) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
      else                   chk("rdata_order", rdata, exp_q.pop_front());
    end
  end

  // One cycle on DUT 1: drive, check at negedge, queue expected data, advance.
  task automatic cyc(input logic r, input logic [31:0] a, input logic g_st,
                     input logic r_st, input logic exp_gnt, input logic exp_rv);
    req  = r;
    addr = a;
    gs   = g_st;
    rs   = r_st;
    @(negedge clk);
    chk("gnt", {31'd0, gnt}, {31'd0, exp_gnt});
    chk("rvalid", {31'd0, rv}, {31'd0, exp_rv});
    if (!exp_rv) chk("rdata_idle_zero", rdata, 32'd0);
    if (exp_gnt) exp_q.push_back(mem_f(a));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input int exp);
    chk("count", 32'(dut.u_fifo.count_q), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    req = 1'b0; addr = '0; gs = 1'b0; rs = 1'b0;
    d3_req = 1'b0; d3_addr = '0;

    // Reset state, including a request presented while reset is held.
    #2;
    req = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_rvalid", {31'd0, rv}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk_cnt(0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req    = 1'b0;
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Back-to-back 0x0, 0x4, 0x8.
    cyc(1, 32'h0, 0, 0, 1, 0);
    cyc(1, 32'h4, 0, 0, 1, 1);
    cyc(1, 32'h8, 0, 0, 1, 1);
    cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 0, 0);
    chk_cnt(0);

    // Response stall for 3 cycles fills the store; full + pop + req.
    cyc(1, 32'h10, 0, 1, 1, 0);
    cyc(1, 32'h14, 0, 1, 1, 0);
    chk_cnt(2);
    cyc(1, 32'h18, 0, 1, 0, 0);
    cyc(1, 32'h18, 0, 0, 0, 1);
    chk_cnt(1);
    cyc(1, 32'h18, 0, 0, 1, 1);
    chk_cnt(1);
    cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 0, 0);
    chk_cnt(0);

    // Grant stall blocks only new grants; the outstanding entry still responds.
    cyc(1, 32'h20, 0, 0, 1, 0);
    cyc(1, 32'h24, 1, 0, 0, 1);
    cyc(1, 32'h24, 0, 0, 1, 0);
    cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Reset with two outstanding requests.
    cyc(1, 32'h30, 0, 1, 1, 0);
    cyc(1, 32'h34, 0, 1, 1, 0);
    chk_cnt(2);
    req    = 1'b1;
    addr   = 32'h38;
    rs     = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_async_rvalid", {31'd0, rv}, 32'd0);
    chk("rst_async_rdata", rdata, 32'd0);
    chk_cnt(0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req    = 1'b0;
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(1, 32'h40, 0, 0, 1, 0);
    cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 0, 0);
    chk_cnt(0);

    // LATENCY=3 instance: single request at 0x100, response only in cycle 3.
    d3_req  = 1'b1;
    d3_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("d3_gnt", {31'd0, d3_gnt}, (k == 0) ? 32'd1 : 32'd0);
      chk("d3_rvalid", {31'd0, d3_rv}, (k == 3) ? 32'd1 : 32'd0);
      chk("d3_rdata", d3_rdata, (k == 3) ? mem_f(32'h100) : 32'd0);
      @(posedge clk);
      #1;
      d3_req = 1'b0;
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/insn_obi_responder.md
INSN_OBI_RESPONDER -- requirements
Module: insn_obi_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the maximum number of outstanding granted requests (1..8).
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the minimum cycles from grant to rvalid (1..15).
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 instr_req_i  input  1  request from the core.
REQ-006 instr_addr_i  input  32  request address, valid while instr_req_i is high.
REQ-007 instr_gnt_o  output  1  grant; the address is accepted when instr_req_i and instr_gnt_o are both high.
REQ-008 instr_rvalid_o  output  1  response valid, one cycle per granted request.
REQ-009 instr_rdata_o  output  32  response data, valid when instr_rvalid_o is high.
REQ-010 gnt_stall_i  input  1  bench control: suppresses grant.
REQ-011 rvalid_stall_i  input  1  bench control: suppresses response.
REQ-012 mem_addr_o  output  32  combinational read address to the external memory model, equal to the head-entry address.
REQ-013 mem_rdata_i  input  32  combinational read data from the external memory model.

Function
REQ-014 instr_gnt_o SHALL equal instr_req_i & ~gnt_stall_i & (count < DEPTH), combinationally.
REQ-015 instr_gnt_o SHALL never be high while instr_req_i is low.
REQ-016 Each accepted request SHALL push {addr, age=0} into an in-order FIFO of DEPTH entries.
REQ-017 Every cycle, each valid entry's age SHALL increment, saturating at LATENCY.
REQ-018 instr_rvalid_o SHALL equal (count >= 1) & (head.age >= LATENCY) & ~rvalid_stall_i.
REQ-019 With LATENCY=1 and no stalls, rvalid SHALL rise exactly one cycle after the grant cycle.
REQ-020 instr_rdata_o SHALL equal mem_rdata_i when instr_rvalid_o is high, and SHALL be 0 otherwise.
REQ-021 When instr_rvalid_o is high, the head entry SHALL pop at the clock edge; responses SHALL be returned in grant order.
REQ-022 The count SHALL be updated as follows: push only gives +1; pop only gives -1; push and pop in the same cycle leave the count unchanged.
REQ-023 When full, the grant SHALL be low even if a pop occurs in the same cycle, so the count never exceeds DEPTH.
REQ-024 instr_rvalid_o SHALL never assert while the count is 0, including in the cycle of the first grant.
REQ-025 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-026 The count SHALL be $clog2(DEPTH+1) bits wide.
REQ-027 A response stalled by rvalid_stall_i SHALL be held (no data loss) and delivered in the first unstalled cycle.
REQ-028 gnt_stall_i SHALL affect only new grants; already-granted entries SHALL keep aging and responding.

Reset
REQ-029 On rst_ni low, the following SHALL clear immediately (asynchronously): count=0, pointers=0, all entries invalid with age=0.
REQ-030 While rst_ni is low, instr_gnt_o=0, instr_rvalid_o=0 and instr_rdata_o=0.
REQ-031 A reset asserted with requests outstanding SHALL discard them; no rvalid SHALL be issued for pre-reset grants.

Structure
REQ-032 A shared package insn_obi_pkg SHALL hold the entry typedef {addr[31:0], age[3:0]}, the DEPTH_MAX=8 constant and the LATENCY_MAX=15 constant.
REQ-033 The FIFO storage, pointers and count SHALL live in the sub-module insn_obi_fifo; the top level SHALL hold the grant and response logic.
REQ-034 The block SHALL be synthesizable and equivalence-checkable, with no $random; variability SHALL come only through the stall inputs.

Verification
REQ-035 Scenario: back-to-back requests at addresses 0x0, 0x4, 0x8 with LATENCY=1, DEPTH=2, no stalls -> grants in cycles 0, 1, 2; rvalid in cycles 1, 2, 3 carrying mem[0x0], mem[0x4], mem[0x8].
REQ-036 Scenario: rvalid_stall_i=1 for 3 cycles with DEPTH=2 -> two grants, then gnt=0 while req=1; after the stall releases, the two rvalids are in order and the count returns to 0.
REQ-037 Scenario: full FIFO with a pop and a request in the same cycle -> gnt=0 that cycle and the count goes 2->1; the grant occurs in the next cycle.
REQ-038 Scenario: LATENCY=3, single request at 0x100 in cycle 0 -> rvalid only in cycle 3, with rdata=mem[0x100].
REQ-039 Scenario: rst_ni pulsed low with 2 outstanding requests -> gnt and rvalid go to 0 immediately; no rvalid after reset release until a new grant has aged LATENCY cycles.
REQ-040 Scenario: a checker SHALL run throughout all scenarios and confirm two properties: gnt is never high without req, and rvalid is never high with count 0.
